// File: rtl/flash_avmm_arbiter.sv
// Burst-atomic round-robin arbiter sharing one flash AVMM port between two masters.
// Optional watchdog enabled by `define FLASH_ARB_TIMEOUT_EN (adds the timeout_err port).
module flash_avmm_arbiter #(
   parameter int unsigned FLASH_ADDR_WIDTH = 28,
   parameter int unsigned TIMEOUT_CYCLES   = 65536
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [FLASH_ADDR_WIDTH-1:0] m0_addr,
   input  logic                        m0_write,
   input  logic                        m0_read,
   input  logic [6:0]                  m0_burstcnt,
   input  logic [31:0]                 m0_wrdata,
   output logic [31:0]                 m0_rddata,
   output logic                        m0_rddvld,
   output logic                        m0_waitreq,
   input  logic [FLASH_ADDR_WIDTH-1:0] m1_addr,
   input  logic                        m1_write,
   input  logic                        m1_read,
   input  logic [6:0]                  m1_burstcnt,
   input  logic [31:0]                 m1_wrdata,
   output logic [31:0]                 m1_rddata,
   output logic                        m1_rddvld,
   output logic                        m1_waitreq,
   output logic [FLASH_ADDR_WIDTH-1:0] s_addr,
   output logic                        s_write,
   output logic                        s_read,
   output logic [6:0]                  s_burstcnt,
   output logic [31:0]                 s_wrdata,
   input  logic [31:0]                 s_rddata,
   input  logic                        s_rddvld,
   input  logic                        s_waitreq,
   output logic [1:0]                  grant,
   output logic                        arb_busy,
   output logic                        burst_err
`ifdef FLASH_ARB_TIMEOUT_EN
   ,
   output logic                        timeout_err
`endif
);

   typedef enum logic [2:0] {StIdle, StWr, StRdCmd, StRdData, StFlush} state_e;

   state_e                      state_q, state_d;
   logic [1:0]                  grant_q, grant_d;
   logic                        last_grant_q, last_grant_d;
   logic [6:0]                  beat_cntr_q, beat_cntr_d;
   logic                        burst_err_q, burst_err_d;

   logic                        own_write, own_read;
   logic [6:0]                  own_cnt;
   logic [FLASH_ADDR_WIDTH-1:0] own_addr;
   logic [31:0]                 own_wrdata;
   logic                        bad_cnt;
   logic [6:0]                  eff_cnt;
   logic                        wr_beat, rd_acc, rd_beat, progress, tmo;
   logic                        fwd_wait, rd_vld;
   logic [31:0]                 rd_dat;

   always_comb begin
      own_write  = 1'b0;
      own_read   = 1'b0;
      own_cnt    = '0;
      own_addr   = '0;
      own_wrdata = '0;
      if (grant_q[0]) begin
         own_write  = m0_write;
         own_read   = m0_read;
         own_cnt    = m0_burstcnt;
         own_addr   = m0_addr;
         own_wrdata = m0_wrdata;
      end else if (grant_q[1]) begin
         own_write  = m1_write;
         own_read   = m1_read;
         own_cnt    = m1_burstcnt;
         own_addr   = m1_addr;
         own_wrdata = m1_wrdata;
      end
   end

   assign bad_cnt  = (own_cnt == 7'd0) || (own_cnt > 7'd64);
   assign eff_cnt  = bad_cnt ? 7'd1 : own_cnt;
   assign wr_beat  = (state_q == StWr) && own_write && !s_waitreq;
   assign rd_acc   = (state_q == StRdCmd) && own_read && !s_waitreq;
   assign rd_beat  = (state_q == StRdData) && s_rddvld;
   assign progress = wr_beat || rd_acc || rd_beat;

`ifdef FLASH_ARB_TIMEOUT_EN
   logic [31:0] wd_q, wd_d;
   logic        timeout_err_q;

   assign tmo = (wd_q >= TIMEOUT_CYCLES) && !progress &&
                ((state_q == StWr) || (state_q == StRdCmd) || (state_q == StRdData));

   always_comb begin
      wd_d = wd_q + 32'd1;
      if ((state_q == StIdle) || (state_q == StFlush) || progress) wd_d = '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wd_q          <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         wd_q          <= wd_d;
         timeout_err_q <= timeout_err_q | tmo;
      end
   end

   assign timeout_err = timeout_err_q;
`else
   assign tmo = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         grant_q      <= 2'b00;
         last_grant_q <= 1'b1;
         beat_cntr_q  <= '0;
         burst_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         beat_cntr_q  <= beat_cntr_d;
         burst_err_q  <= burst_err_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      beat_cntr_d  = beat_cntr_q;
      burst_err_d  = burst_err_q;
      unique case (state_q)
         StIdle: begin
            // last_grant_q is the index of the previous winner; the other master wins a tie
            if ((m0_write || m0_read) && (!(m1_write || m1_read) || last_grant_q)) begin
               grant_d      = 2'b01;
               last_grant_d = 1'b0;
               state_d      = m0_write ? StWr : StRdCmd;
            end else if (m1_write || m1_read) begin
               grant_d      = 2'b10;
               last_grant_d = 1'b1;
               state_d      = m1_write ? StWr : StRdCmd;
            end
         end
         StWr: begin
            if (wr_beat) begin
               // A zero count marks the first beat; the counter holds beats still to come
               if (beat_cntr_q == 7'd0) begin
                  burst_err_d = burst_err_q | bad_cnt;
                  beat_cntr_d = eff_cnt - 7'd1;
                  if (eff_cnt == 7'd1) begin
                     state_d = StIdle;
                     grant_d = 2'b00;
                  end
               end else begin
                  beat_cntr_d = beat_cntr_q - 7'd1;
                  if (beat_cntr_q == 7'd1) begin
                     state_d = StIdle;
                     grant_d = 2'b00;
                  end
               end
            end
         end
         StRdCmd: begin
            if (rd_acc) begin
               burst_err_d = burst_err_q | bad_cnt;
               beat_cntr_d = eff_cnt;
               state_d     = StRdData;
            end
         end
         StRdData: begin
            if (rd_beat) begin
               beat_cntr_d = beat_cntr_q - 7'd1;
               if (beat_cntr_q <= 7'd1) begin
                  state_d = StIdle;
                  grant_d = 2'b00;
               end
            end
         end
         StFlush: begin
            beat_cntr_d = beat_cntr_q - 7'd1;
            if (beat_cntr_q <= 7'd1) begin
               state_d = StIdle;
               grant_d = 2'b00;
            end
         end
         default: begin
            state_d = StIdle;
            grant_d = 2'b00;
         end
      endcase
      if (tmo) begin
         if (state_q == StRdData) begin
            state_d = StFlush;
         end else begin
            state_d     = StIdle;
            grant_d     = 2'b00;
            beat_cntr_d = '0;
         end
      end
   end

   assign fwd_wait = ((state_q == StWr) || (state_q == StRdCmd)) && !tmo ? s_waitreq : 1'b1;
   assign rd_vld   = rd_beat || (state_q == StFlush);
   assign rd_dat   = (state_q == StFlush) ? 32'hDEADBEEF : s_rddata;

   always_comb begin
      s_addr     = own_addr;
      s_burstcnt = own_cnt;
      s_wrdata   = own_wrdata;
      s_write    = (state_q == StWr) && own_write && !tmo;
      s_read     = (state_q == StRdCmd) && own_read && !tmo;
      m0_waitreq = 1'b1;
      m1_waitreq = 1'b1;
      m0_rddvld  = 1'b0;
      m1_rddvld  = 1'b0;
      m0_rddata  = '0;
      m1_rddata  = '0;
      if (grant_q[0]) begin
         m0_waitreq = fwd_wait;
         m0_rddvld  = rd_vld;
         m0_rddata  = rd_vld ? rd_dat : 32'd0;
      end
      if (grant_q[1]) begin
         m1_waitreq = fwd_wait;
         m1_rddvld  = rd_vld;
         m1_rddata  = rd_vld ? rd_dat : 32'd0;
      end
   end

   assign grant     = grant_q;
   assign arb_busy  = (state_q != StIdle);
   assign burst_err = burst_err_q;

endmodule

// File: tb/tb_flash_avmm_arbiter.sv
// Directed bench for flash_avmm_arbiter: a per-cycle vector table plus write/stall/fairness
// sequences; the watchdog sequence is built only with FLASH_ARB_TIMEOUT_EN.
module tb_flash_avmm_arbiter;

   localparam int AW  = 28;
   localparam int TMO = 100;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] m0_addr, m1_addr, s_addr;
   logic          m0_write, m0_read, m1_write, m1_read;
   logic [6:0]    m0_burstcnt, m1_burstcnt, s_burstcnt;
   logic [31:0]   m0_wrdata, m1_wrdata, m0_rddata, m1_rddata, s_wrdata, s_rddata;
   logic          m0_rddvld, m1_rddvld, m0_waitreq, m1_waitreq;
   logic          s_write, s_read, s_rddvld, s_waitreq;
   logic [1:0]    grant;
   logic          arb_busy, burst_err;
`ifdef FLASH_ARB_TIMEOUT_EN
   logic          timeout_err;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   flash_avmm_arbiter #(
      .FLASH_ADDR_WIDTH(AW),
      .TIMEOUT_CYCLES  (TMO)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .m0_addr    (m0_addr),
      .m0_write   (m0_write),
      .m0_read    (m0_read),
      .m0_burstcnt(m0_burstcnt),
      .m0_wrdata  (m0_wrdata),
      .m0_rddata  (m0_rddata),
      .m0_rddvld  (m0_rddvld),
      .m0_waitreq (m0_waitreq),
      .m1_addr    (m1_addr),
      .m1_write   (m1_write),
      .m1_read    (m1_read),
      .m1_burstcnt(m1_burstcnt),
      .m1_wrdata  (m1_wrdata),
      .m1_rddata  (m1_rddata),
      .m1_rddvld  (m1_rddvld),
      .m1_waitreq (m1_waitreq),
      .s_addr     (s_addr),
      .s_write    (s_write),
      .s_read     (s_read),
      .s_burstcnt (s_burstcnt),
      .s_wrdata   (s_wrdata),
      .s_rddata   (s_rddata),
      .s_rddvld   (s_rddvld),
      .s_waitreq  (s_waitreq),
      .grant      (grant),
      .arb_busy   (arb_busy),
      .burst_err  (burst_err)
`ifdef FLASH_ARB_TIMEOUT_EN
      ,
      .timeout_err(timeout_err)
`endif
   );

   typedef struct {
      logic        rst;
      logic        m0r;
      logic [6:0]  m0c;
      logic        m1r;
      logic [6:0]  m1c;
      logic        sdv;
      logic [31:0] sdat;
      logic [1:0]  gnt;
      logic        sr;
      logic        w0, w1, v0, v1, berr, busy;
   } vec_t;

   localparam int NV = 28;
   vec_t tbl[NV];

   function automatic vec_t mk(input logic rst, input logic m0r, input logic [6:0] m0c,
                               input logic m1r, input logic [6:0] m1c, input logic sdv,
                               input logic [31:0] sdat, input logic [1:0] gnt, input logic sr,
                               input logic w0, input logic w1, input logic v0, input logic v1,
                               input logic berr, input logic busy);
      vec_t v;
      v.rst = rst;  v.m0r = m0r; v.m0c = m0c; v.m1r = m1r; v.m1c = m1c;
      v.sdv = sdv;  v.sdat = sdat; v.gnt = gnt; v.sr = sr;
      v.w0 = w0;    v.w1 = w1;   v.v0 = v0;   v.v1 = v1;  v.berr = berr; v.busy = busy;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      m0_write = 0; m0_read = 0; m1_write = 0; m1_read = 0;
      m0_burstcnt = 0; m1_burstcnt = 0; m0_wrdata = 0; m1_wrdata = 0;
      m0_addr = 28'h0000100; m1_addr = 28'h0000200;
      s_rddvld = 0; s_rddata = 0; s_waitreq = 1'b0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Called at a negedge with master m already owning the port in WR.
   task automatic wr_beats(input int m, input int n, input int stall_at, input int stall_len,
                           input logic [31:0] seed, input string tag);
      int i = 0;
      int stalled = 0;
      int guard = 0;
      while (i < n && guard < 400) begin
         if (m == 0) m0_wrdata = seed + i; else m1_wrdata = seed + i;
         s_waitreq = (i == stall_at) && (stalled < stall_len);
         #1;
         chk($sformatf("%s beat%0d grant", tag, i), grant, (m == 0) ? 2'b01 : 2'b10);
         chk($sformatf("%s beat%0d s_write", tag, i), s_write, 1);
         chk($sformatf("%s beat%0d s_wrdata", tag, i), s_wrdata, seed + i);
         chk($sformatf("%s beat%0d waitreq", tag, i), (m == 0) ? m0_waitreq : m1_waitreq,
             s_waitreq);
         if (s_waitreq) stalled++; else i++;
         guard++;
         @(negedge clk);
      end
      s_waitreq = 1'b0;
      chk({tag, " beats accepted"}, i, n);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global time limit: got running, expected finished");
      $fatal(1, "time limit");
   end

   initial begin
      reset = 1'b1;
      m0_write = 0; m0_read = 0; m1_write = 0; m1_read = 0;
      m0_burstcnt = 0; m1_burstcnt = 0; m0_wrdata = 0; m1_wrdata = 0;
      m0_addr = 0; m1_addr = 0; s_rddvld = 0; s_rddata = 0; s_waitreq = 0;

      //           rst m0r m0c m1r m1c sdv sdat      gnt sr w0 w1 v0 v1 be by
      tbl[0]  = mk(0,  0,  0,  0,  0,  0,  0,            0, 0, 1, 1, 0, 0, 0, 0);
      tbl[1]  = mk(0,  1,  4,  1,  4,  0,  0,            0, 0, 1, 1, 0, 0, 0, 0);
      tbl[2]  = mk(0,  1,  4,  1,  4,  0,  0,            1, 1, 0, 1, 0, 0, 0, 1);
      tbl[3]  = mk(0,  0,  4,  1,  4,  0,  0,            1, 0, 1, 1, 0, 0, 0, 1);
      tbl[4]  = mk(0,  0,  4,  1,  4,  1,  32'hA0000001, 1, 0, 1, 1, 1, 0, 0, 1);
      tbl[5]  = mk(0,  0,  4,  1,  4,  1,  32'hA0000002, 1, 0, 1, 1, 1, 0, 0, 1);
      tbl[6]  = mk(0,  0,  4,  1,  4,  0,  0,            1, 0, 1, 1, 0, 0, 0, 1);
      tbl[7]  = mk(0,  0,  4,  1,  4,  1,  32'hA0000003, 1, 0, 1, 1, 1, 0, 0, 1);
      tbl[8]  = mk(0,  0,  4,  1,  4,  1,  32'hA0000004, 1, 0, 1, 1, 1, 0, 0, 1);
      tbl[9]  = mk(0,  0,  4,  1,  4,  1,  32'h5EEEEEE5, 0, 0, 1, 1, 0, 0, 0, 0);
      tbl[10] = mk(0,  0,  0,  1,  4,  0,  0,            2, 1, 1, 0, 0, 0, 0, 1);
      tbl[11] = mk(0,  0,  0,  0,  4,  1,  32'hB0000001, 2, 0, 1, 1, 0, 1, 0, 1);
      tbl[12] = mk(0,  0,  0,  0,  4,  1,  32'hB0000002, 2, 0, 1, 1, 0, 1, 0, 1);
      tbl[13] = mk(0,  0,  0,  0,  4,  1,  32'hB0000003, 2, 0, 1, 1, 0, 1, 0, 1);
      tbl[14] = mk(0,  0,  0,  0,  4,  1,  32'hB0000004, 2, 0, 1, 1, 0, 1, 0, 1);
      tbl[15] = mk(0,  0,  0,  0,  4,  1,  32'h5EEEEEE5, 0, 0, 1, 1, 0, 0, 0, 0);
      tbl[16] = mk(0,  0,  0,  1,  0,  0,  0,            0, 0, 1, 1, 0, 0, 0, 0);
      tbl[17] = mk(0,  0,  0,  1,  0,  0,  0,            2, 1, 1, 0, 0, 0, 0, 1);
      tbl[18] = mk(0,  0,  0,  0,  0,  1,  32'hC0000001, 2, 0, 1, 1, 0, 1, 1, 1);
      tbl[19] = mk(0,  0,  0,  0,  0,  0,  0,            0, 0, 1, 1, 0, 0, 1, 0);
      tbl[20] = mk(0,  0,  0,  0,  0,  1,  32'h5EEEEEE5, 0, 0, 1, 1, 0, 0, 1, 0);
      tbl[21] = mk(0,  1,  8,  0,  0,  0,  0,            0, 0, 1, 1, 0, 0, 1, 0);
      tbl[22] = mk(0,  1,  8,  0,  0,  0,  0,            1, 1, 0, 1, 0, 0, 1, 1);
      tbl[23] = mk(0,  0,  8,  0,  0,  1,  32'hD0000001, 1, 0, 1, 1, 1, 0, 1, 1);
      tbl[24] = mk(0,  0,  8,  0,  0,  1,  32'hD0000002, 1, 0, 1, 1, 1, 0, 1, 1);
      tbl[25] = mk(1,  0,  8,  0,  0,  1,  32'hD0000003, 1, 0, 1, 1, 1, 0, 1, 1);
      tbl[26] = mk(0,  0,  8,  0,  0,  1,  32'h5EEEEEE5, 0, 0, 1, 1, 0, 0, 0, 0);
      tbl[27] = mk(0,  0,  8,  0,  0,  1,  32'h5EEEEEE6, 0, 0, 1, 1, 0, 0, 0, 0);

      do_reset();
      for (int k = 0; k < NV; k++) begin
         @(negedge clk);
         reset       = tbl[k].rst;
         m0_read     = tbl[k].m0r;
         m0_burstcnt = tbl[k].m0c;
         m1_read     = tbl[k].m1r;
         m1_burstcnt = tbl[k].m1c;
         s_rddvld    = tbl[k].sdv;
         s_rddata    = tbl[k].sdat;
         s_waitreq   = 1'b0;
         #1;
         chk($sformatf("row%0d grant", k), grant, tbl[k].gnt);
         chk($sformatf("row%0d s_read", k), s_read, tbl[k].sr);
         chk($sformatf("row%0d s_write", k), s_write, 0);
         chk($sformatf("row%0d m0_waitreq", k), m0_waitreq, tbl[k].w0);
         chk($sformatf("row%0d m1_waitreq", k), m1_waitreq, tbl[k].w1);
         chk($sformatf("row%0d m0_rddvld", k), m0_rddvld, tbl[k].v0);
         chk($sformatf("row%0d m1_rddvld", k), m1_rddvld, tbl[k].v1);
         chk($sformatf("row%0d burst_err", k), burst_err, tbl[k].berr);
         chk($sformatf("row%0d arb_busy", k), arb_busy, tbl[k].busy);
         if (tbl[k].v0) chk($sformatf("row%0d m0_rddata", k), m0_rddata, tbl[k].sdat);
         if (tbl[k].v1) chk($sformatf("row%0d m1_rddata", k), m1_rddata, tbl[k].sdat);
      end

      // 64-beat write from m0 with m1 idle
      do_reset();
      m0_write = 1'b1; m0_burstcnt = 7'd64; m0_addr = 28'h0ABCDE0; m0_wrdata = 32'h64000000;
      #1;
      chk("w64 idle grant", grant, 2'b00);
      chk("w64 idle m0_waitreq", m0_waitreq, 1);
      @(negedge clk);
      #1;
      chk("w64 s_addr", s_addr, 28'h0ABCDE0);
      chk("w64 s_burstcnt", s_burstcnt, 64);
      wr_beats(0, 64, -1, 0, 32'h64000000, "w64");
      m0_write = 1'b0;
      #1;
      chk("w64 end busy", arb_busy, 0);
      chk("w64 end grant", grant, 2'b00);
      chk("w64 end m0_waitreq", m0_waitreq, 1);

      // m1 write stalled for 10 cycles at beat 5
      do_reset();
      m1_write = 1'b1; m1_burstcnt = 7'd16;
      @(negedge clk);
      wr_beats(1, 16, 5, 10, 32'h57A10000, "stall");
      m1_write = 1'b0;
      #1;
      chk("stall end busy", arb_busy, 0);

      // m0 back-to-back writes while m1 holds a read: m0, m1, m0
      do_reset();
      m0_write = 1'b1; m0_burstcnt = 7'd16; m1_read = 1'b1; m1_burstcnt = 7'd1;
      #1;
      chk("alt idle grant", grant, 2'b00);
      @(negedge clk);
      wr_beats(0, 16, -1, 0, 32'h10000000, "alt m0a");
      #1;
      chk("alt gap grant", grant, 2'b00);
      @(negedge clk);
      #1;
      chk("alt m1 grant", grant, 2'b10);
      chk("alt m1 s_read", s_read, 1);
      chk("alt m0 waitreq", m0_waitreq, 1);
      @(negedge clk);
      m1_read = 1'b0; s_rddvld = 1'b1; s_rddata = 32'hCAFE0001;
      #1;
      chk("alt m1 rddvld", m1_rddvld, 1);
      chk("alt m1 rddata", m1_rddata, 32'hCAFE0001);
      chk("alt m0 rddvld", m0_rddvld, 0);
      @(negedge clk);
      s_rddvld = 1'b0;
      #1;
      chk("alt gap2 grant", grant, 2'b00);
      @(negedge clk);
      wr_beats(0, 16, -1, 0, 32'h20000000, "alt m0b");
      m0_write = 1'b0;
      #1;
      chk("alt end busy", arb_busy, 0);

`ifdef FLASH_ARB_TIMEOUT_EN
      // Read of 8 beats where the controller stops after beat 2
      begin
         int dead = 0;
         int cyc  = 0;
         do_reset();
         m1_read = 1'b1; m1_burstcnt = 7'd8;
         @(negedge clk);
         #1;
         chk("tmo s_read", s_read, 1);
         @(negedge clk);
         m1_read = 1'b0;
         for (int k = 0; k < 2; k++) begin
            s_rddvld = 1'b1; s_rddata = 32'h7000 + k;
            #1;
            chk($sformatf("tmo beat%0d rddvld", k), m1_rddvld, 1);
            @(negedge clk);
         end
         s_rddvld = 1'b0;
         #1;
         while (arb_busy && cyc < 300) begin
            if (m1_rddvld && (m1_rddata == 32'hDEADBEEF)) dead++;
            @(negedge clk);
            #1;
            cyc++;
         end
         chk("tmo idle", arb_busy, 0);
         chk("tmo deadbeef beats", dead, 6);
         chk("tmo timeout_err", timeout_err, 1);
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/flash_avmm_arbiter.md
Name: flash_avmm_arbiter

Overview:
- Shares the single AVMM port of the flash controller between two burst-capable masters.
- m0 is the flash burst master (host write/read/RSU path); m1 is the BMC-side direct flash master.
- Arbitration is round-robin and burst-atomic: the winner keeps the port until its write burst is fully transferred, or until all its read data has returned.
- Read data is routed back only to the owning master.

Parameters:
- FLASH_ADDR_WIDTH, 28, flash address width on all ports.
- TIMEOUT_CYCLES, 65536, watchdog limit; used only with FLASH_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- mN_addr  in  FLASH_ADDR_WIDTH  master N address (N=0,1; all mN_* ports exist for both masters).
- mN_write / mN_read  in  1  master N write / read request.
- mN_burstcnt  in  7  master N burst length, 1..64.
- mN_wrdata  in  32  master N write data.
- mN_rddata  out  32  read data to master N.
- mN_rddvld  out  1  read data valid to master N.
- mN_waitreq  out  1  waitrequest to master N.
- s_addr  out  FLASH_ADDR_WIDTH  address to flash controller.
- s_write / s_read  out  1  write / read to flash controller.
- s_burstcnt  out  7  burst length to flash controller.
- s_wrdata  out  32  write data to flash controller.
- s_rddata  in  32  read data from flash controller.
- s_rddvld  in  1  read data valid from flash controller.
- s_waitreq  in  1  waitrequest from flash controller.
- grant  out  2  one-hot current owner; 0 when idle.
- arb_busy  out  1  high in any state other than IDLE.
- burst_err  out  1  sticky; set when burstcnt of 0 or above 64 is seen.

Behaviour:
Reset:
- state=IDLE, grant=0, last_grant=1 (m0 wins the first tie), beat_cntr=0, burst_err=0.
- Outputs: s_write=s_read=0, mN_rddvld=0, mN_waitreq=1.
- Reset mid-burst aborts the burst immediately with no flush. Late s_rddvld arriving after reset is dropped.

Request and arbitration:
- reqN = mN_write | mN_read.
- IDLE: if exactly one master requests, grant it. If both request, grant the master that is not last_grant.
- grant and last_grant are registered, so arbitration costs one cycle. Both mN_waitreq stay 1 in IDLE.
- Non-granted master: mN_waitreq=1 and mN_rddvld=0 at all times.

Burst length:
- eff_cnt = mN_burstcnt, except 0 or >64 is treated as 1 and sets burst_err.

State WR (granted master asserted write):
- s_* is combinationally muxed from the owner; mN_waitreq = s_waitreq.
- beat_cntr is loaded with eff_cnt on the first accepted beat, then decrements on each s_write & !s_waitreq.
- The beat that makes the remaining count 0 moves the FSM to IDLE on the next edge.
- s_addr and s_burstcnt are forwarded unchanged; the flash controller samples them on the first beat.

State RD_CMD (granted master asserted read):
- s_read is forwarded until !s_waitreq. On acceptance: beat_cntr=eff_cnt, go to RD_DATA.

State RD_DATA:
- Owner waitreq=1; s_read=0.
- Each s_rddvld drives owner mN_rddvld=1 and mN_rddata=s_rddata combinationally, zero latency, and decrements beat_cntr.
- At count 0: go to IDLE.
- s_rddvld in IDLE, WR or RD_CMD is dropped.

Ordering and fairness:
- Simultaneous write and read from one master: write wins.
- Back-to-back requests from one master while the other requests: the other wins the next arbitration.
- Worst-case wait = one full 64-beat burst + 1 cycle.

Optional Feature:
FLASH_ARB_TIMEOUT_EN
- Defined: a 32-bit watchdog counts cycles in WR, RD_CMD and RD_DATA with no beat progress (accepted write, accepted read or s_rddvld). On reaching TIMEOUT_CYCLES:
  - Assert sticky output timeout_err (port exists only with the macro).
  - In RD_DATA, return the remaining beats to the owner, one per cycle, with rddata=32'hDEADBEEF.
  - Deassert s_write/s_read, then go to IDLE.
  - The counter resets on any progress and on entering IDLE.
- Undefined: no watchdog, no timeout_err port; the arbiter waits indefinitely.

Test Plan:
- m0 write burstcnt=64, m1 idle -> grant=01 one cycle after request; 64 s_write beats with wrdata in order; IDLE after beat 64; m0_waitreq=1 throughout IDLE.
- m0 and m1 both read burstcnt=4 in the same cycle after reset -> m0 served first: 4 m0_rddvld and 0 m1_rddvld; then m1 receives exactly 4 beats.
- m0 issues continuous 16-beat writes while m1 holds a read -> grants alternate m0,m1,m0; m1 starts within 17 cycles of m0 burst end.
- s_waitreq held high 10 cycles mid write burst -> beat_cntr frozen; no beat lost or duplicated; s_wrdata stable while stalled.
- m1 read burstcnt=0 -> treated as 1 beat; burst_err=1 and stays set until reset.
- Reset asserted at read beat 3 of 8 -> next cycle state=IDLE, grant=0, both waitreq=1; stray s_rddvld not forwarded. With FLASH_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=100: withhold s_rddvld after beat 2 of 8 -> timeout_err=1 and 6 beats of 32'hDEADBEEF returned.
